countdown: RTL and testbench

// - Two-digit decimal countdown timer with 7-segment outputs and end-of-count beep flag.
// - A prescaler divides the system clock into a 1 Hz tick. A BCD counter decrements from a start value to 00 on each tick.
// - Both digits are decoded to active-low 7-segment patterns for a board display.
// - Top-level block: drives the two display digits and the buzzer enable directly.

---
 rtl/countdown_pkg.sv | 37 +++
 rtl/countdown_seg7_decoder.sv | 14 +
 rtl/countdown.sv | 81 ++++++++
 tb/tb_countdown.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared segment patterns and BCD-to-7-segment decode for the countdown timer.
// Patterns are active-low with bit order {g,f,e,d,c,b,a}.
`timescale 1ns/1ps
package countdown_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/countdown_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; codes above 9 blank the digit.
`timescale 1ns/1ps
module seg7_decoder
    import countdown_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_decode(digit);
    end

endmodule

// File: rtl/countdown.sv
// Two-digit BCD countdown timer: prescaled tick, sticky 00 terminal state with beep flag,
// and two 7-segment digit outputs.
`timescale 1ns/1ps
module countdown
    import countdown_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 25_000_000,
    parameter int unsigned START_TENS = 5,
    parameter int unsigned START_ONES = 9
) (
    input  logic       clock,
    input  logic       reset,
    output logic [6:0] bs1,
    output logic [6:0] bs0,
    output logic       beep
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [3:0] START_T = 4'(START_TENS);
    localparam logic [3:0] START_O = 4'(START_ONES);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          beep_q, beep_d;
    logic          tick;
    logic          at_zero;
    logic          at_one;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            tens_q  <= START_T;
            ones_q  <= START_O;
            beep_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            beep_q  <= beep_d;
        end
    end

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
        at_one  = (tens_q == 4'd0) && (ones_q == 4'd1);
        tens_d  = tens_q;
        ones_d  = ones_q;
        if (tick && !at_zero) begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end
        end
        // Beep latches on the tick that lands on 00, or the first tick when already at 00.
        beep_d = beep_q | (tick & (at_one | at_zero));
    end

    always_comb begin
        beep = beep_q;
    end

    seg7_decoder u_tens (
        .digit (tens_q),
        .seg   (bs1)
    );

    seg7_decoder u_ones (
        .digit (ones_q),
        .seg   (bs0)
    );

endmodule

// File: tb/tb_countdown.sv
// Scoreboard bench for countdown: several parameterisations share one clock, each with
// its own reset, and expected display/beep values are queued then compared.
`timescale 1ns/1ps
module tb_countdown;

    typedef struct {
        string      name;
        logic [14:0] val;
    } exp_t;

    logic clock = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;
    logic rst_d = 1'b0;

    logic [6:0] bs1_a, bs0_a, bs1_b, bs0_b, bs1_c, bs0_c, bs1_d, bs0_d;
    logic       beep_a, beep_b, beep_c, beep_d;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t e;

    always #20 clock = ~clock;

    countdown #(.CLK_DIV(4), .START_TENS(5), .START_ONES(9)) u_a (
        .clock (clock), .reset (rst_a), .bs1 (bs1_a), .bs0 (bs0_a), .beep (beep_a)
    );
    countdown #(.CLK_DIV(1), .START_TENS(1), .START_ONES(0)) u_b (
        .clock (clock), .reset (rst_b), .bs1 (bs1_b), .bs0 (bs0_b), .beep (beep_b)
    );
    countdown #(.CLK_DIV(1), .START_TENS(0), .START_ONES(2)) u_c (
        .clock (clock), .reset (rst_c), .bs1 (bs1_c), .bs0 (bs0_c), .beep (beep_c)
    );
    countdown #(.CLK_DIV(2), .START_TENS(0), .START_ONES(0)) u_d (
        .clock (clock), .reset (rst_d), .bs1 (bs1_d), .bs0 (bs0_d), .beep (beep_d)
    );

    wire [14:0] obs_a = {bs1_a, bs0_a, beep_a};
    wire [14:0] obs_b = {bs1_b, bs0_b, beep_b};
    wire [14:0] obs_c = {bs1_c, bs0_c, beep_c};
    wire [14:0] obs_d = {bs1_d, bs0_d, beep_d};

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t mk(input string name, input int count, input bit bp);
        exp_t r;
        r.name = name;
        r.val  = {seg_ref(count / 10), seg_ref(count % 10), bp};
        return r;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            sb.push_back(mk($sformatf("reset_hold_%0d", i), 59, 1'b0));
            e = sb.pop_front();
            checks++;
            if (obs_a !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.name, obs_a, e.val);
            end
        end
        sb.push_back(mk("reset_start00", 0, 1'b0));
        e = sb.pop_front();
        checks++;
        if (obs_d !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.name, obs_d, e.val);
        end
    endtask

    task automatic test_prescale();
        @(negedge clock);
        rst_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock);
            sb.push_back(mk($sformatf("prescale_cyc%0d", c), 59 - c / 4, 1'b0));
            #1;
            e = sb.pop_front();
            checks++;
            if (obs_a !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.name, obs_a, e.val);
            end
        end
    endtask

    task automatic test_borrow();
        @(negedge clock);
        rst_b = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clock);
            sb.push_back(mk($sformatf("borrow_tick%0d", c), 10 - c, 1'b0));
            #1;
            e = sb.pop_front();
            checks++;
            if (obs_b !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.name, obs_b, e.val);
            end
        end
    endtask

    task automatic test_terminal();
        @(negedge clock);
        rst_c = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock);
            sb.push_back(mk($sformatf("terminal_tick%0d", c), (c >= 2) ? 0 : 1, c >= 2));
            #1;
            e = sb.pop_front();
            checks++;
            if (obs_c !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.name, obs_c, e.val);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        rst_a = 1'b0;
        @(negedge clock);
        rst_a = 1'b1;
        repeat (88) @(posedge clock);
        sb.push_back(mk("async_before_37", 37, 1'b0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs_a !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.name, obs_a, e.val);
        end
        #10;
        rst_a = 1'b0;
        sb.push_back(mk("async_reload_59", 59, 1'b0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs_a !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.name, obs_a, e.val);
        end
        @(posedge clock);
        sb.push_back(mk("async_held_59", 59, 1'b0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs_a !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.name, obs_a, e.val);
        end
    endtask

    task automatic test_start00();
        @(negedge clock);
        rst_d = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock);
            sb.push_back(mk($sformatf("start00_cyc%0d", c), 0, c >= 2));
            #1;
            e = sb.pop_front();
            checks++;
            if (obs_d !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.name, obs_d, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_borrow();
        test_terminal();
        test_async_reset();
        test_start00();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
